// File: rtl/clk_div_meter_if.sv
// Measurement result bundle of clk_div_meter: period/high time, divider estimate, lock and timeout.
// With CLK_DIV_METER_AVG_EN defined the bundle also carries the 4-sample period average.
interface clk_div_meter_if #(
  parameter int unsigned CNT_W = 16
);
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] div_n_est;
  logic             meas_valid;
  logic             locked;
  logic             timeout;
`ifdef CLK_DIV_METER_AVG_EN
  logic [CNT_W-1:0] period_avg;
  logic             avg_valid;

  modport master (
    output period, high_cnt, div_n_est, meas_valid, locked, timeout, period_avg, avg_valid
  );
  modport slave (
    input period, high_cnt, div_n_est, meas_valid, locked, timeout, period_avg, avg_valid
  );
`else
  modport master (output period, high_cnt, div_n_est, meas_valid, locked, timeout);
  modport slave (input period, high_cnt, div_n_est, meas_valid, locked, timeout);
`endif
endinterface

// File: rtl/clk_div_meter.sv
// Measures period and high time of an asynchronous divided clock in clk cycles, with lock
// detection and no-signal timeout. Optional period averaging via macro CLK_DIV_METER_AVG_EN.
module clk_div_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_CNT    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic            sig_in_i,
  clk_div_meter_if.master meas_if
);

  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [CNT_W-1:0] CntArmMax = CntMax - CNT_W'(1);
  localparam int unsigned      MatchW    = $clog2(LOCK_CNT);
  localparam logic [MatchW-1:0] MatchTop = MatchW'(LOCK_CNT - 1);

  typedef enum logic [1:0] {StIdle, StArm, StMeas} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d1_q, rise_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0]       period_q, period_d, high_q, high_d, div_q, div_d;
  logic                   pend_q, pend_d, match_q, match_d;
  logic                   mvalid_q, mvalid_d, locked_q, locked_d, timeout_q, timeout_d;
  logic [MatchW-1:0]      mcnt_q, mcnt_d;
  logic                   hist_clr;

  // rise_q and s_d1_q are aligned: both describe the same synchronized sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d1_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in_i};
      s_d1_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~s_d1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      div_q     <= '0;
      pend_q    <= 1'b0;
      match_q   <= 1'b0;
      mvalid_q  <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      mcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      match_q   <= match_d;
      mvalid_q  <= mvalid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
      mcnt_q    <= mcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    div_d     = div_q;
    pend_d    = 1'b0;
    match_d   = match_q;
    mvalid_d  = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    mcnt_d    = mcnt_q;
    hist_clr  = 1'b0;
    if (!en_i) begin
      state_d   = StIdle;
      cnt_d     = '0;
      hcnt_d    = '0;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
      mcnt_d    = '0;
      hist_clr  = 1'b1;
    end else begin
      // Outputs were captured last cycle; publish them together with the lock verdict.
      if (pend_q) begin
        mvalid_d  = 1'b1;
        timeout_d = 1'b0;
        if (!match_q) begin
          mcnt_d = '0;
        end else if (mcnt_q != MatchTop) begin
          mcnt_d = mcnt_q + MatchW'(1);
        end
        locked_d = (mcnt_d == MatchTop);
      end
      unique case (state_q)
        StIdle: begin
          cnt_d    = '0;
          hcnt_d   = '0;
          hist_clr = 1'b1;
          state_d  = StArm;
        end
        StArm: begin
          if (rise_q) begin
            cnt_d   = CNT_W'(1);
            hcnt_d  = CNT_W'(1);
            state_d = StMeas;
          end else if (cnt_q == CntArmMax) begin
            cnt_d     = '0;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            mcnt_d    = '0;
            hist_clr  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StMeas: begin
          if (rise_q) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            div_d    = cnt_q - CNT_W'(1);
            match_d  = (cnt_q == period_q) && (hcnt_q == high_q);
            pend_d   = 1'b1;
            cnt_d    = CNT_W'(1);
            hcnt_d   = CNT_W'(1);
          end else if (cnt_q == CntMax) begin
            cnt_d     = '0;
            hcnt_d    = '0;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            mcnt_d    = '0;
            hist_clr  = 1'b1;
            state_d   = StArm;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, s_d1_q};
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign meas_if.period     = period_q;
  assign meas_if.high_cnt   = high_q;
  assign meas_if.div_n_est  = div_q;
  assign meas_if.meas_valid = mvalid_q;
  assign meas_if.locked     = locked_q;
  assign meas_if.timeout    = timeout_q;

`ifdef CLK_DIV_METER_AVG_EN
  // Three older periods; the freshly captured period_q is the fourth term of the sum.
  logic [CNT_W-1:0] hist_q [3];
  logic [2:0]       navg_q;
  logic [CNT_W-1:0] avg_q;
  logic             avg_valid_q;
  logic [CNT_W+1:0] sum_w;

  assign sum_w = (CNT_W+2)'(hist_q[0]) + (CNT_W+2)'(hist_q[1]) + (CNT_W+2)'(hist_q[2])
               + (CNT_W+2)'(period_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q      <= '{default: '0};
      navg_q      <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else if (hist_clr) begin
      hist_q      <= '{default: '0};
      navg_q      <= '0;
      avg_valid_q <= 1'b0;
    end else if (pend_q) begin
      hist_q[2]   <= hist_q[1];
      hist_q[1]   <= hist_q[0];
      hist_q[0]   <= period_q;
      avg_q       <= sum_w[CNT_W+1:2];
      navg_q      <= (navg_q == 3'd4) ? navg_q : navg_q + 3'd1;
      avg_valid_q <= (navg_q >= 3'd3);
    end
  end

  assign meas_if.period_avg = avg_q;
  assign meas_if.avg_valid  = avg_valid_q;
`else
  logic unused_hist_clr;
  assign unused_hist_clr = hist_clr;
`endif

endmodule

// File: tb/tb_clk_div_meter.sv
// Randomized scoreboard bench for clk_div_meter: a phase-level waveform model predicts each
// measurement; a monitor checks every meas_valid against the queue.
module tb_clk_div_meter;
  localparam int unsigned CntW    = 8;
  localparam int          LockCnt = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic sig_in = 1'b0;

  always #5 clk = ~clk;

  clk_div_meter_if #(.CNT_W(CntW)) mif ();

  clk_div_meter #(
    .CNT_W      (CntW),
    .SYNC_STAGES(2),
    .LOCK_CNT   (LockCnt)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .sig_in_i(sig_in),
    .meas_if (mif)
  );

  typedef struct {
    int period;
    int high;
    bit locked;
    bit chk_gap;
    int avg;
    bit avg_valid;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_mv = 0;

  // Model state: rises are known from the generated phases (high, low lengths).
  bit en_m = 0;
  bit armed = 0;
  int prev_h = 0, prev_l = 0;
  int last_p = 0, last_h = 0;
  int mcnt = 0;
  int run_cnt = 0;
  int hist[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic lose_arm();
    armed   = 0;
    mcnt    = 0;
    run_cnt = 0;
    hist.delete();
  endtask

  task automatic model_rise(input int h, input int l);
    exp_t e;
    int   sum;
    if (en_m) begin
      if (!armed) begin
        armed = 1;
      end else begin
        e.period = prev_h + prev_l;
        e.high   = prev_h;
        if (e.period == last_p && e.high == last_h) mcnt = (mcnt < LockCnt - 1) ? mcnt + 1 : mcnt;
        else mcnt = 0;
        last_p   = e.period;
        last_h   = e.high;
        e.locked = (mcnt >= LockCnt - 1);
        e.chk_gap = (run_cnt > 0);
        run_cnt++;
        hist.push_back(e.period);
        if (hist.size() > 4) void'(hist.pop_front());
        sum = 0;
        foreach (hist[i]) sum += hist[i];
        e.avg       = sum / 4;
        e.avg_valid = (hist.size() == 4);
        exp_q.push_back(e);
      end
    end
    prev_h = h;
    prev_l = l;
  endtask

  // One full high+low phase starting with a rise; optionally drop en at step drop_at.
  task automatic drive_phase(input int h, input int l, input int drop_at);
    for (int i = 0; i < h + l; i++) begin
      @(negedge clk);
      if (i == 0) model_rise(h, l);
      sig_in = (i < h);
      if (drop_at != 0 && i == drop_at) begin
        en   = 1'b0;
        en_m = 0;
        lose_arm();
      end
    end
  endtask

  task automatic set_en();
    @(negedge clk);
    en   = 1'b1;
    en_m = 1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, int'(mif.period), 0);
    check({tag, "_high_cnt"}, int'(mif.high_cnt), 0);
    check({tag, "_div_n_est"}, int'(mif.div_n_est), 0);
    check({tag, "_meas_valid"}, int'(mif.meas_valid), 0);
    check({tag, "_locked"}, int'(mif.locked), 0);
    check({tag, "_timeout"}, int'(mif.timeout), 0);
`ifdef CLK_DIV_METER_AVG_EN
    check({tag, "_period_avg"}, int'(mif.period_avg), 0);
    check({tag, "_avg_valid"}, int'(mif.avg_valid), 0);
`endif
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mif.meas_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_meas_valid: got period %0d, expected no measurement", mif.period);
      end else begin
        e = exp_q.pop_front();
        check("period", int'(mif.period), e.period);
        check("high_cnt", int'(mif.high_cnt), e.high);
        check("div_n_est", int'(mif.div_n_est), e.period - 1);
        check("locked", int'(mif.locked), int'(e.locked));
        check("timeout_at_meas", int'(mif.timeout), 0);
        if (e.chk_gap) check("meas_spacing", cyc - last_mv, e.period);
`ifdef CLK_DIV_METER_AVG_EN
        check("period_avg", int'(mif.period_avg), e.avg);
        check("avg_valid", int'(mif.avg_valid), int'(e.avg_valid));
`endif
      end
      last_mv = cyc;
    end
  end

  initial begin
    int h, l;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    set_en();
    repeat (3) @(negedge clk);

    repeat (7) drive_phase(5, 5, 0);   // div_n = 9
    repeat (6) drive_phase(4, 3, 0);   // div_n = 6, relock
    repeat (6) drive_phase(3, 2, 0);   // div_n = 4
    for (int k = 0; k < 4; k++) begin
      h = $urandom_range(2, 9);
      l = $urandom_range(2, 9);
      repeat ($urandom_range(1, 5)) drive_phase(h, l, 0);
      drive_phase($urandom_range(2, 9), $urandom_range(2, 9), 0);
    end

    // en dropped mid-period: outputs hold, lock lost, rises ignored
    drive_phase(5, 5, 0);
    drive_phase(5, 5, 7);
    repeat (2) @(negedge clk);
    check("en_off_locked", int'(mif.locked), 0);
    check("en_off_period_hold", int'(mif.period), last_p);
    check("en_off_high_hold", int'(mif.high_cnt), last_h);
    repeat (2) drive_phase(5, 5, 0);
    set_en();
    repeat (6) drive_phase(6, 4, 0);

    // no-signal timeout
    drive_phase(5, 100, 0);
    check("timeout_early", int'(mif.timeout), 0);
    repeat (200) @(negedge clk);
    check("timeout_set", int'(mif.timeout), 1);
    check("timeout_locked", int'(mif.locked), 0);
    lose_arm();
    repeat (5) drive_phase(5, 5, 0);
    check("timeout_cleared", int'(mif.timeout), 0);

    // reset mid-stream, then 10,10,12,12 sequence
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    exp_q.delete();
    last_p = 0;
    last_h = 0;
    lose_arm();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    drive_phase(5, 5, 0);
    drive_phase(5, 5, 0);
    drive_phase(6, 6, 0);
    drive_phase(6, 6, 0);
    drive_phase(5, 5, 0);
    repeat (3) drive_phase(5, 5, 0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
